divider_seq_112_56: RTL and testbench
=====================================

Name: divider_seq_112_56

Overview:
- Sequential unsigned restoring divider: 2*div_size-bit dividend / div_size-bit divisor -> div_size-bit quotient + div_size-bit remainder.
- Inverse of the 56x56 DSP multipliers: recovers the quotient/remainder pair for modular-reduction checks and for precomputing Barrett constants (mu = floor(2^(2*radix)/M)).
- Sits beside the multiplier pipeline. Start/busy/done handshake to the reduction controller.

Parameters:
- div_size, 56, divisor/quotient/remainder width; dividend is 2*div_size.
- cnt_w, 6, iteration counter width; must satisfy 2^cnt_w > div_size.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only when busy=0
- dividend  in  2*div_size  sampled on accepted start
- divisor  in  div_size  sampled on accepted start
- busy  out  1  high from the cycle after acceptance through the done cycle
- done  out  1  single-cycle pulse; results valid this cycle and held afterwards
- quotient  out  div_size  result, held until the next accepted start
- remainder  out  div_size  result, held until the next accepted start
- err_div0  out  1  divisor was zero; valid with done, held
- err_ovf  out  1  quotient does not fit in div_size bits; valid with done, held

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy, done, err_div0, err_ovf, quotient, remainder, counter all 0. Reset overrides start in the same cycle. Reset mid-operation aborts with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 -> latch operands, go to CHECK.
  - CHECK: divisor==0 -> err_div0=1, go to DONE. Else if dividend[2*div_size-1:div_size] >= divisor -> err_ovf=1, go to DONE. Else go to RUN, with partial remainder = dividend high half, shift register = dividend low half, counter = div_size.
  - RUN: one quotient bit per cycle, MSB first. Trial = {pr, next dividend bit} - divisor, computed at div_size+1 bits. Non-negative -> pr = trial, qbit 1; negative -> restore, qbit 0. Counter decrements; at counter==1 go to DONE after the last bit.
  - DONE: done=1 for exactly 1 cycle; quotient/remainder registers updated; go to IDLE.
- Error results:
  - div0: quotient = all ones, remainder = dividend[div_size-1:0].
  - ovf: quotient = all ones, remainder = 0.
  - err_div0 and err_ovf are never both 1.
- Latency: start accepted at edge T.
  - Normal operation: done high in cycle T+div_size+2 (58 for defaults).
  - Error cases: done high in cycle T+2.
  - Back-to-back: next start is accepted in the cycle after done (IDLE). start during busy is ignored, not queued.
- Flags, quotient and remainder hold their last values until the CHECK of the next operation, which clears both flags.
- Invariant for every non-error result: dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro DIVIDER_RADIX4_EN.
- Defined: RUN retires 2 quotient bits per cycle (two cascaded trial subtractions); counter starts at div_size/2. Normal done at T+div_size/2+2 (30). div_size must be even; an odd value is a compile-time error.
- Undefined: radix-2 as described above. Error-path timing, results and ports are identical in both builds.

Decomposition:
- Shared package div_pkg: state enum (IDLE, CHECK, RUN, DONE), default DIV_SIZE=56, DIV_LAT = DIV_SIZE+2 (or DIV_SIZE/2+2 in the radix-4 build) for testbench timing checks.
- One natural sub-module: div_step, the combinational trial-subtract/restore stage (pr, dividend bit, divisor -> new pr, qbit). Instantiated once (radix-2) or twice chained (radix-4).

Test Plan:
- Basic: dividend=100, divisor=7, start at T -> done at T+58, quotient=14, remainder=2, both flags 0, busy low at T+59.
- Max legal: divisor=2^56-1, dividend=2^112-2^56-1 -> quotient=2^56-1, remainder=2^56-2, err_ovf=0.
- Divide by zero: divisor=0, dividend=123 -> done at T+2, err_div0=1, quotient=2^56-1, remainder=123.
- Overflow: dividend={56'd5, 56'd0}, divisor=5 -> done at T+2, err_ovf=1, quotient=2^56-1, remainder=0. A following legal op (100/7) clears err_ovf.
- Handshake/reset: start with 100/7, pulse start with other operands at T+5 -> ignored, result 14 r 2. Then start again and assert rst at T+10 -> busy=0, no done, outputs 0.
- DIVIDER_RADIX4_EN build: 100/7 -> done at T+30, same results. Random 1000-op regression checks the invariant in both builds.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider.
// DIVIDER_RADIX4_EN selects the two-bits-per-cycle build; DIV_LAT follows it.
package div_pkg;

  localparam int DIV_SIZE = 56;

`ifdef DIVIDER_RADIX4_EN
  localparam int DIV_LAT = DIV_SIZE / 2 + 2;
`else
  localparam int DIV_LAT = DIV_SIZE + 2;
`endif

  // FSM encoding (IDLE, CHECK, RUN, DONE)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try subtracting the divisor, keep the difference if non-negative.
module div_step #(
  parameter int W = 56
) (
  input  logic [W-1:0] pr,
  input  logic         din,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] pr_nxt,
  output logic         qbit
);

  logic [W:0]   cur;
  logic [W+1:0] trial;

  // Extra top bit acts as the borrow; pr < dvs keeps the kept result in W bits
  assign cur    = {pr, din};
  assign trial  = {1'b0, cur} - {2'b00, dvs};
  assign qbit   = ~trial[W+1];
  assign pr_nxt = qbit ? W'(trial) : W'(cur);

endmodule

// File: rtl/divider_seq_112_56.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor.
// Optional build macro DIVIDER_RADIX4_EN retires two quotient bits per cycle.
module divider_seq_112_56
  import div_pkg::*;
#(
  parameter int div_size = DIV_SIZE,
  parameter int cnt_w    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*div_size-1:0] dividend,
  input  logic [div_size-1:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [div_size-1:0]   quotient,
  output logic [div_size-1:0]   remainder,
  output logic                  err_div0,
  output logic                  err_ovf
);

  localparam int W = div_size;

  if ((2 ** cnt_w) <= div_size) begin : g_cnt_chk
    $error("cnt_w too narrow for div_size");
  end

  logic [1:0]       state;
  logic [W-1:0]     pr;    // partial remainder (dividend high half at start)
  logic [W-1:0]     sr;    // dividend low half shifting out, quotient shifting in
  logic [W-1:0]     dvs;
  logic [cnt_w-1:0] cnt;
  logic [W-1:0]     pr_nxt;
  logic [W-1:0]     sr_nxt;

`ifdef DIVIDER_RADIX4_EN
  localparam logic [cnt_w-1:0] CNT_INIT = cnt_w'(W / 2);

  if ((div_size % 2) != 0) begin : g_odd_chk
    $error("radix-4 build needs an even div_size");
  end

  logic [W-1:0] pr_mid;
  logic         q_hi;
  logic         q_lo;

  div_step #(.W(W)) u_step0 (
    .pr     (pr),
    .din    (sr[W-1]),
    .dvs    (dvs),
    .pr_nxt (pr_mid),
    .qbit   (q_hi)
  );

  div_step #(.W(W)) u_step1 (
    .pr     (pr_mid),
    .din    (sr[W-2]),
    .dvs    (dvs),
    .pr_nxt (pr_nxt),
    .qbit   (q_lo)
  );

  assign sr_nxt = {sr[W-3:0], q_hi, q_lo};
`else
  localparam logic [cnt_w-1:0] CNT_INIT = cnt_w'(W);

  logic q_bit;

  div_step #(.W(W)) u_step0 (
    .pr     (pr),
    .din    (sr[W-1]),
    .dvs    (dvs),
    .pr_nxt (pr_nxt),
    .qbit   (q_bit)
  );

  assign sr_nxt = {sr[W-2:0], q_bit};
`endif

  // Control FSM, datapath registers and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_div0  <= 1'b0;
      err_ovf   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      pr        <= '0;
      sr        <= '0;
      dvs       <= '0;
    end else begin
      done <= 1'b0;
      // busy covers the done cycle, so a start during done is ignored
      if (done) busy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            pr    <= dividend[2*W-1:W];
            sr    <= dividend[W-1:0];
            dvs   <= divisor;
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_div0 <= 1'b0;
          err_ovf  <= 1'b0;
          // Error results are staged in pr/sr so DONE copies them uniformly
          if (dvs == '0) begin
            err_div0 <= 1'b1;
            pr       <= sr;
            sr       <= '1;
            state    <= ST_DONE;
          end else if (pr >= dvs) begin
            err_ovf <= 1'b1;
            pr      <= '0;
            sr      <= '1;
            state   <= ST_DONE;
          end else begin
            cnt   <= CNT_INIT;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          pr  <= pr_nxt;
          sr  <= sr_nxt;
          cnt <= cnt - cnt_w'(1);
          if (cnt == cnt_w'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b1;
          quotient  <= sr;
          remainder <= pr;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_112_56.sv
// Directed bench for divider_seq_112_56 (either build; latency from DIV_LAT).
module tb_divider_seq_112_56;
  import div_pkg::*;

  localparam int W = DIV_SIZE;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, done, err_div0, err_ovf;
  logic [W-1:0]   quotient, remainder;

  int checks = 0;
  int errors = 0;

  divider_seq_112_56 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err_div0  (err_div0),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns #1 after the accepting edge
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                        input int lat, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic d0, input logic ov);
    int k;
    issue(dd, dv);
    wait_done(k);
    check({tag, "_lat"}, 128'(k), 128'(lat));
    check({tag, "_q"}, 128'(quotient), 128'(q));
    check({tag, "_r"}, 128'(remainder), 128'(r));
    check({tag, "_div0"}, 128'(err_div0), 128'(d0));
    check({tag, "_ovf"}, 128'(err_ovf), 128'(ov));
    check({tag, "_busy_at_done"}, 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 128'(done), 128'(0));
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int k;
    logic seen;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_q", 128'(quotient), 128'(0));
    check("rst_r", 128'(remainder), 128'(0));
    check("rst_flags", 128'({err_div0, err_ovf}), 128'(0));
    rst = 1'b0;

    run_op("basic", 112'd100, 56'd7, DIV_LAT, 56'd14, 56'd2, 1'b0, 1'b0);
    run_op("maxlegal", {56'hFFFFFFFFFFFFFE, 56'hFFFFFFFFFFFFFF}, ONES, DIV_LAT,
           ONES, 56'hFFFFFFFFFFFFFE, 1'b0, 1'b0);
    // 2^80 / (2^40+1) = 2^40-1 remainder 1
    run_op("pow80", 112'h1 << 80, 56'h00010000000001, DIV_LAT,
           56'h000000FFFFFFFFFF, 56'd1, 1'b0, 1'b0);
    run_op("small", 112'd5, 56'd7, DIV_LAT, 56'd0, 56'd5, 1'b0, 1'b0);
    run_op("div1", 112'h0000ABCD12345678, 56'd1, DIV_LAT, 56'h0000ABCD12345678, 56'd0, 1'b0, 1'b0);

    run_op("div0", 112'd123, 56'd0, 2, ONES, 56'd123, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("div0_hold_flag", 128'(err_div0), 128'(1));
    check("div0_hold_q", 128'(quotient), 128'(ONES));
    // zero divisor wins over a high half that would also overflow
    run_op("div0_big", {56'd1, 56'hABC}, 56'd0, 2, ONES, 56'hABC, 1'b1, 1'b0);

    run_op("ovf", {56'd5, 56'd0}, 56'd5, 2, ONES, 56'd0, 1'b0, 1'b1);
    run_op("after_ovf", 112'd100, 56'd7, DIV_LAT, 56'd14, 56'd2, 1'b0, 1'b0);

    // start while busy is ignored
    issue(112'd100, 56'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 112'd1000;
    divisor  = 56'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(k);
    check("ign_lat", 128'(k + 5), 128'(DIV_LAT));
    check("ign_q", 128'(quotient), 128'(14));
    check("ign_r", 128'(remainder), 128'(2));
    @(posedge clk);
    #1;

    // reset mid-operation aborts with no done
    issue(112'd1000, 56'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_q", 128'(quotient), 128'(0));
    check("abort_r", 128'(remainder), 128'(0));
    rst  = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 128'(seen), 128'(0));
    check("abort_idle_busy", 128'(busy), 128'(0));

    run_op("post_rst", 112'd1000, 56'd3, DIV_LAT, 56'd333, 56'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
